// File: rtl/pam4_rx_slicer.sv
// -----------------------------------------------------------------------------
// pam4_rx_slicer
//   Receive-side symbol recovery for one QAM branch (I or Q). Takes the
//   OSR-times oversampled, 18-bit signed output of the receive SRRC matched
//   filter, picks the decision phase with the most energy over an acquisition
//   window, then decimates and slices each symbol to 4-PAM Gray bits
//   (00=-3, 01=-1, 11=+1, 10=+3).
//
//   Build option: PAM4_RX_FIXED_PHASE_EN
//     defined   - acquisition removed; reset state is TRACK at PHASE_INIT
//     undefined - full energy-based phase acquisition (ACQ -> SEL -> TRACK)
//
// Parameters
//   OSR        oversampling ratio (power of 2, >= 2)
//   ACQ_SYMS   symbols per acquisition window (power of 2)
//   THRESH     outer/inner decision threshold (0 < THRESH < 2^17)
//   PHASE_INIT phase used before/without acquisition (0..OSR-1)
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_en      sample strobe; i_din consumed only when high
//   i_din     signed filtered sample
//   o_dout    recovered symbol bits (held until next o_valid)
//   o_valid   one-cycle pulse when o_dout carries a new symbol
//   o_locked  high while in TRACK
//   o_phase   selected decision phase
// -----------------------------------------------------------------------------
module pam4_rx_slicer #(
  parameter int OSR        = 4,
  parameter int ACQ_SYMS   = 16,
  parameter int THRESH     = 16384,
  parameter int PHASE_INIT = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic signed [17:0]         i_din,
  output logic [1:0]                 o_dout,
  output logic                       o_valid,
  output logic                       o_locked,
  output logic [$clog2(OSR)-1:0]     o_phase
);

  localparam int PW = $clog2(OSR);

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [PW-1:0]     CNT_LAST   = PW'(OSR - 1);
  localparam logic [PW-1:0]     PH_INIT    = PW'(PHASE_INIT);
  localparam logic signed [17:0] THR_POS   = 18'(THRESH);
  localparam logic signed [17:0] THR_NEG   = 18'(-THRESH);

`ifndef PAM4_RX_FIXED_PHASE_EN
  localparam int SW = $clog2(ACQ_SYMS) + 1;
  localparam int AW = 17 + $clog2(ACQ_SYMS);
  localparam logic [SW-1:0] SYM_LAST = SW'(ACQ_SYMS - 1);
`endif

  // Four-level Gray decision against +/-THRESH.
  function automatic logic [1:0] slice_sym(input logic signed [17:0] d);
    logic [1:0] s;
    if (d >= THR_POS) begin
      s = 2'b10;
    end else if (d >= 18'sd0) begin
      s = 2'b11;
    end else if (d >= THR_NEG) begin
      s = 2'b01;
    end else begin
      s = 2'b00;
    end
    return s;
  endfunction

  logic [1:0]    r_state;
  logic [PW-1:0] r_cnt;

`ifndef PAM4_RX_FIXED_PHASE_EN
  // Magnitude of a sample; the single unrepresentable value -2^17 clips
  // to 2^17-1 so the result always fits 17 bits.
  function automatic logic [16:0] abs_sat(input logic signed [17:0] d);
    logic [17:0] m;
    if (d == 18'sh20000) begin
      m = 18'h1FFFF;
    end else if (d < 18'sd0) begin
      m = 18'(-d);
    end else begin
      m = d;
    end
    return m[16:0];
  endfunction

  logic [AW-1:0] r_acc [OSR];
  logic [SW-1:0] r_sym_cnt;
  logic [16:0]   w_abs;
  logic [AW-1:0] w_best_val;
  logic [PW-1:0] w_best_idx;

  // Sample magnitude for energy accumulation.
  always_comb begin
    w_abs = abs_sat(i_din);
  end

  // Argmax over the phase accumulators; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best_val = r_acc[0];
    w_best_idx = '0;
    for (int k = 1; k < OSR; k++) begin
      if (r_acc[k] > w_best_val) begin
        w_best_val = r_acc[k];
        w_best_idx = PW'(k);
      end else begin
        w_best_val = w_best_val;
        w_best_idx = w_best_idx;
      end
    end
  end

  // Acquisition accumulators and symbol counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < OSR; k++) begin
        r_acc[k] <= '0;
      end
      r_sym_cnt <= '0;
    end else if (r_state == ST_SEL) begin
      for (int k = 0; k < OSR; k++) begin
        r_acc[k] <= '0;
      end
      r_sym_cnt <= '0;
    end else if ((r_state == ST_ACQ) && i_en) begin
      r_acc[r_cnt] <= r_acc[r_cnt] + AW'(w_abs);
      if (r_cnt == CNT_LAST) begin
        r_sym_cnt <= r_sym_cnt + SW'(1);
      end
    end
  end
`endif

  // Sample-phase counter: advances on every strobe in every state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  // Control FSM, phase/lock outputs and registered slicer output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout   <= 2'b00;
      o_valid  <= 1'b0;
      o_phase  <= PH_INIT;
`ifdef PAM4_RX_FIXED_PHASE_EN
      r_state  <= ST_TRACK;
      o_locked <= 1'b1;
`else
      r_state  <= ST_ACQ;
      o_locked <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (r_state)
`ifndef PAM4_RX_FIXED_PHASE_EN
        ST_ACQ: begin
          // Window ends on the edge that accumulates its last sample.
          if (i_en && (r_cnt == CNT_LAST) && (r_sym_cnt == SYM_LAST)) begin
            r_state <= ST_SEL;
          end
        end
        ST_SEL: begin
          o_phase  <= w_best_idx;
          o_locked <= 1'b1;
          r_state  <= ST_TRACK;
        end
`endif
        ST_TRACK: begin
          if (i_en && (r_cnt == o_phase)) begin
            o_dout  <= slice_sym(i_din);
            o_valid <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean start.
          o_phase  <= PH_INIT;
`ifdef PAM4_RX_FIXED_PHASE_EN
          r_state  <= ST_TRACK;
          o_locked <= 1'b1;
`else
          r_state  <= ST_ACQ;
          o_locked <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pam4_rx_slicer.sv
module tb_pam4_rx_slicer;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [17:0] din;
  logic [1:0]         dout;
  logic               valid;
  logic               locked;
  logic [1:0]         phase;

  int n_assert = 0;
  int n_fail   = 0;
  int tb_cnt   = 0;   // bench's own sample-phase counter
  int nv;

  pam4_rx_slicer #(
    .OSR(4), .ACQ_SYMS(16), .THRESH(16384), .PHASE_INIT(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din),
    .o_dout(dout), .o_valid(valid), .o_locked(locked), .o_phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, wait for the edge, settle 1 time unit.
  task automatic step(input logic e, input logic signed [17:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
    if (e) tb_cnt = (tb_cnt + 1) % 4;
  endtask

  // Stream n en-samples in TRACK; dec goes at phase ph, oth elsewhere.
  task automatic track(input string tag, input int n, input int ph,
                       input logic signed [17:0] dec, input logic signed [17:0] oth,
                       input logic [1:0] exp, output int nvalid);
    int pc;
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      pc = tb_cnt;
      step(1'b1, (pc == ph) ? dec : oth);
      chk({tag, "_valid"}, valid, (pc == ph) ? 1 : 0);
      if (valid) nvalid++;
      if (pc == ph) chk({tag, "_dout"}, dout, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 18'sd0);
    rst = 1'b0;
    tb_cnt = 0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = 18'sd0;
    @(negedge clk);

    // ---- reset state
    rst = 1'b1;
    step(1'b0, 18'sd0);
    step(1'b0, 18'sd0);
    rst = 1'b0;
    tb_cnt = 0;
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_phase", phase, 0);

    // ---- acquisition: +30000 at phase 2
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (tb_cnt == 2) ? 18'sd30000 : 18'sd0);
      chk("acq_valid", valid, 0);
      chk("acq_locked", locked, 0);
    end
    step(1'b1, 18'sd30000);               // SEL cycle: not sliced
    chk("sel_valid", valid, 0);
    chk("sel_locked", locked, 1);
    chk("sel_phase", phase, 2);
    track("trk", 8, 2, 18'sd30000, 18'sd0, 2'b10, nv);
    chk("trk_count", nv, 2);

    // ---- slicer boundaries at phase 2 (off-phase samples would slice 00)
    track("b16384", 4, 2, 18'sd16384, -18'sd131072, 2'b10, nv);
    track("b16383", 4, 2, 18'sd16383, -18'sd131072, 2'b11, nv);
    track("b0",     4, 2, 18'sd0,     -18'sd131072, 2'b11, nv);
    track("bm1",    4, 2, -18'sd1,    18'sd100000,  2'b01, nv);
    track("bm16384",4, 2, -18'sd16384,18'sd100000,  2'b01, nv);
    track("bm16385",4, 2, -18'sd16385,18'sd100000,  2'b00, nv);

    // ---- en gap mid-symbol
    step(1'b1, (tb_cnt == 2) ? 18'sd30000 : 18'sd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 18'sd30000);
      chk("gap_valid", valid, 0);
    end
    chk("gap_dout_hold", dout, 2'b00);
    track("post_gap", 8, 2, -18'sd20000, 18'sd0, 2'b00, nv);
    chk("post_gap_count", nv, 2);

    // ---- reset mid-TRACK
    rst = 1'b1;
    step(1'b1, 18'sd30000);
    rst = 1'b0;
    tb_cnt = 0;
    chk("mrst_dout", dout, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_phase", phase, 0);

    // ---- tie / saturation: -131072 at cnt 3, +131071 at cnt 1
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (tb_cnt == 3) ? -18'sd131072 : ((tb_cnt == 1) ? 18'sd131071 : 18'sd0));
    end
    chk("tie_locked_sel", locked, 0);
    step(1'b1, 18'sd0);                   // SEL
    chk("tie_locked", locked, 1);
    chk("tie_phase", phase, 1);
    track("tie_trk", 8, 1, -18'sd5, 18'sd30000, 2'b01, nv);
    chk("tie_count", nv, 2);

    // ---- all-zero window with en gaps carrying large values; SEL with en=0
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 18'sd0);
      if (tb_cnt == 3) step(1'b0, 18'sd100000);
    end
    chk("zero_locked_sel", locked, 0);
    step(1'b0, 18'sd100000);              // SEL with en low: cnt frozen
    chk("zero_locked", locked, 1);
    chk("zero_phase", phase, 0);
    chk("zero_sel_valid", valid, 0);
    track("zero_trk", 8, 0, 18'sd16384, -18'sd1, 2'b10, nv);
    chk("zero_count", nv, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pam4_rx_slicer.md
# pam4_rx_slicer

Receive-side symbol recovery for one QAM branch (I or Q): accepts the 18-bit signed, OSR-times oversampled output of the receive SRRC matched filter and returns 2-bit symbols. It is the mirror of the transmit SRRC path, which takes 2-bit symbols in and produces 18-bit samples. It performs energy-based symbol-phase acquisition, then decimates and slices each symbol to 4-PAM Gray bits. One instance is used per branch.

## Interface
- OSR, 4, oversampling ratio; power of 2, ≥2
- ACQ_SYMS, 16, symbols per acquisition window; power of 2
- THRESH, 16384, outer/inner decision threshold (positive, < 2^17)
- PHASE_INIT, 0, phase used before acquisition completes or when acquisition is compiled out; range 0..OSR-1
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe; Din is consumed only in cycles with en=1
- Din  in  18  signed two's-complement filtered sample
- Dout  out  2  recovered symbol bits
- valid  out  1  one-cycle pulse; Dout holds a new symbol
- locked  out  1  high while in TRACK
- phase  out  clog2(OSR)  selected decision phase

## Operation
- The sample counter `cnt` runs from 0 to OSR-1.
  - It advances by one on every en=1 cycle in all states and wraps at OSR-1.
  - It is frozen when en=0.
- **States:** ACQ, SEL, TRACK. The reset state is ACQ.
- **ACQ:**
  - Each en=1 sample adds |Din| into accumulator `acc[cnt]`.
  - |−131072| saturates to 131071.
  - Accumulator width is 17+clog2(ACQ_SYMS), so no overflow is possible.
  - `sym_cnt` increments when en=1 and cnt=OSR-1.
  - When sym_cnt reaches ACQ_SYMS (that is, the last sample of the window is accumulated), the next state is SEL.
  - Outputs: valid=0, locked=0.
- **SEL:**
  - Lasts exactly one cycle regardless of en.
  - `phase` is set to the argmax of acc. On a tie, the lowest index wins.
  - All accumulators and sym_cnt are cleared.
  - cnt still advances if en=1. The SEL-cycle sample is neither accumulated nor sliced.
  - Next state is TRACK.
- **TRACK:**
  - On en=1 with cnt==phase, Din is sliced:
    - Din ≥ THRESH → 2'b10
    - 0 ≤ Din < THRESH → 2'b11
    - −THRESH ≤ Din < 0 → 2'b01
    - Din < −THRESH → 2'b00
  - These bits are the same Gray map the transmitter uses (00=−3, 01=−1, 11=+1, 10=+3).
  - TRACK is left only by reset.
- en=0 at any point:
  - No accumulation and no slicing.
  - valid=0.
  - State is unchanged. SEL still completes in its one cycle.

## Timing
- **Reset values:** Dout=2'b00, valid=0, locked=0, phase=PHASE_INIT, cnt=0, sym_cnt=0, acc=0, state=ACQ.
- **Slicing latency:** Dout and valid are registered. valid rises in the cycle after the decision-sample edge and lasts one cycle. Dout holds until the next valid.
- **locked:** rises on the same edge that enters TRACK, which is the edge ending SEL. phase updates on that same edge.
- **Acquisition time:** the first valid can occur no earlier than ACQ_SYMS·OSR en-samples plus one SEL cycle after reset.
- **Reset mid-operation:** rst=1 in any state reinstates all reset values on that edge. Acquisition restarts from zero.
- Adjacent valid pulses are separated by ≥ OSR cycles.

## Configuration
- **PAM4_RX_FIXED_PHASE_EN defined:**
  - ACQ and SEL and the accumulators are removed.
  - The reset state is TRACK with phase=PHASE_INIT and locked=1 from reset release.
  - The first decision is at the first en sample with cnt==PHASE_INIT.
- **Undefined:** full acquisition as described above.

## Test plan
- **Acquisition:** defaults. Every symbol is Din=+30000 at cnt=2 and 0 at the other phases, for 64 en-cycles. → SEL, then locked=1 and phase=2. Afterwards Dout=2'b10 with valid every 4th cycle, one cycle after each cnt=2 sample.
- **Slicer boundaries:** in TRACK (fixed phase), decision samples 16384, 16383, 0, −1, −16384, −16385 → Dout = 10, 11, 11, 01, 01, 00 respectively.
- **Tie / saturation:** all-zero input through ACQ → phase=0. A window of Din=−131072 at cnt=3 and +131071 at cnt=1 → tie, so phase=1.
- **en gaps:** in TRACK, drop en for 5 cycles mid-symbol → no valid during the gap. Decision alignment resumes on the correct phase; symbols are neither lost nor duplicated.
- **Reset mid-TRACK:** assert rst for 1 cycle → next cycle Dout=00, valid=0, locked=0, phase=PHASE_INIT. Re-acquisition takes 64 en-samples + SEL.
- **PAM4_RX_FIXED_PHASE_EN** with PHASE_INIT=1 → locked=1 immediately after reset. The first valid follows the first cnt=1 sample.
